sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 34 +++
 rtl/sync_fifo.sv | 128 ++++++++++++
 tb/tb_sync_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO and its storage.
package sync_fifo_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH = 16;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      while (v != 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, async or registered read.
module fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter bit          ASYNC_READ = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we,
   input  logic [clog2(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      re,
   input  logic [clog2(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]          rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port; only the output register is reset, never the array.
   always_ff @(posedge clk) begin
      if (reset)   rdata_q <= '0;
      else if (re) rdata_q <= mem[raddr];
   end

   assign rdata = ASYNC_READ ? mem[raddr] : rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, sticky error flags and optional FWFT read.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = DEFAULT_WIDTH,
   parameter int unsigned DEPTH    = DEFAULT_DEPTH,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter int unsigned FWFT     = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write,
   input  logic [WIDTH-1:0]             write_data,
   input  logic                         read,
   output logic [WIDTH-1:0]             read_data,
   output logic                         read_valid,
   input  logic                         flush,
   input  logic                         clear_flags,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         overflow,
   output logic                         underflow,
   output logic [clog2(DEPTH+1)-1:0]    level
);

   localparam int unsigned AW        = clog2(DEPTH);
   localparam int unsigned LW        = clog2(DEPTH + 1);
   localparam bit          FWFT_MODE = (FWFT != 0);

   logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_n, wr_ptr_n;
   logic [LW-1:0] level_q, level_n;
   logic          overflow_q, underflow_q, overflow_n, underflow_n;
   logic          full_q, empty_q, af_q, ae_q;
   logic          full_n, empty_n, af_n, ae_n;
   logic          rv_q;
   logic          rd_acc_c, wr_acc_c;
   logic [WIDTH-1:0] ram_rdata;

   // Wrap explicitly at DEPTH-1 so non-power-of-two depths work.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      rd_acc_c    = read && !empty_q && !flush;
      wr_acc_c    = write && (!full_q || rd_acc_c) && !flush;
      rd_ptr_n    = rd_ptr_q;
      wr_ptr_n    = wr_ptr_q;
      level_n     = level_q;
      overflow_n  = clear_flags ? 1'b0 : overflow_q;
      underflow_n = clear_flags ? 1'b0 : underflow_q;

      // Error events override a same-cycle clear.
      if (!flush && write && !wr_acc_c) overflow_n  = 1'b1;
      if (!flush && read && empty_q)    underflow_n = 1'b1;

      if (flush) begin
         rd_ptr_n = '0;
         wr_ptr_n = '0;
         level_n  = '0;
      end else begin
         if (rd_acc_c) rd_ptr_n = ptr_inc(rd_ptr_q);
         if (wr_acc_c) wr_ptr_n = ptr_inc(wr_ptr_q);
         if (wr_acc_c && !rd_acc_c)      level_n = level_q + LW'(1);
         else if (rd_acc_c && !wr_acc_c) level_n = level_q - LW'(1);
      end

      full_n  = (level_n == LW'(DEPTH));
      empty_n = (level_n == '0);
      af_n    = (32'(level_n) >= AF_LEVEL);
      ae_n    = (32'(level_n) <= AE_LEVEL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         af_q        <= (AF_LEVEL == 0);
         ae_q        <= 1'b1;
         rv_q        <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_n;
         wr_ptr_q    <= wr_ptr_n;
         level_q     <= level_n;
         overflow_q  <= overflow_n;
         underflow_q <= underflow_n;
         full_q      <= full_n;
         empty_q     <= empty_n;
         af_q        <= af_n;
         ae_q        <= ae_n;
         rv_q        <= rd_acc_c;
      end
   end

   fifo_ram #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ASYNC_READ (FWFT_MODE)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_acc_c),
      .waddr (wr_ptr_q),
      .wdata (write_data),
      .re    (rd_acc_c),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   assign read_data    = ram_rdata;
   assign read_valid   = FWFT_MODE ? !empty_q : rv_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign level        = level_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench: DEPTH=16 FWFT, DEPTH=5 FWFT, DEPTH=4 registered read.
module tb_sync_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Instance A: DEPTH=16, FWFT
   logic       a_rst, a_wr, a_rd, a_fl, a_cf;
   logic [7:0] a_wd, a_rdat;
   logic       a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
   logic [4:0] a_lvl;

   // Instance B: DEPTH=5, FWFT
   logic       b_rst, b_wr, b_rd, b_fl, b_cf;
   logic [7:0] b_wd, b_rdat;
   logic       b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
   logic [2:0] b_lvl;

   // Instance C: DEPTH=4, registered read
   logic       c_rst, c_wr, c_rd, c_fl, c_cf;
   logic [7:0] c_wd, c_rdat;
   logic       c_rv, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
   logic [2:0] c_lvl;

   sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_a (
      .clk(clk), .reset(a_rst), .write(a_wr), .write_data(a_wd), .read(a_rd),
      .read_data(a_rdat), .read_valid(a_rv), .flush(a_fl), .clear_flags(a_cf),
      .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
      .overflow(a_ovf), .underflow(a_unf), .level(a_lvl));

   sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_b (
      .clk(clk), .reset(b_rst), .write(b_wr), .write_data(b_wd), .read(b_rd),
      .read_data(b_rdat), .read_valid(b_rv), .flush(b_fl), .clear_flags(b_cf),
      .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
      .overflow(b_ovf), .underflow(b_unf), .level(b_lvl));

   sync_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_c (
      .clk(clk), .reset(c_rst), .write(c_wr), .write_data(c_wd), .read(c_rd),
      .read_data(c_rdat), .read_valid(c_rv), .flush(c_fl), .clear_flags(c_cf),
      .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
      .overflow(c_ovf), .underflow(c_unf), .level(c_lvl));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_b;
      {a_wr, a_rd, a_fl, a_cf, a_wd} = '0;
      {b_wr, b_rd, b_fl, b_cf, b_wd} = '0;
      {c_wr, c_rd, c_fl, c_cf, c_wd} = '0;
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      tick;
      tick;
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

      // Reset state
      check("a_rst_empty", a_empty, 1);
      check("a_rst_full",  a_full,  0);
      check("a_rst_ae",    a_ae,    1);
      check("a_rst_af",    a_af,    0);
      check("a_rst_level", a_lvl,   0);
      check("a_rst_ovf",   a_ovf,   0);
      check("a_rst_unf",   a_unf,   0);
      check("a_rst_rv",    a_rv,    0);
      check("c_rst_rdata", c_rdat,  0);
      check("c_rst_rv",    c_rv,    0);

      // Fill 16, overflow on 17th, drain in order
      for (int i = 0; i < 16; i++) begin
         a_wr = 1'b1; a_wd = 8'(i);
         tick;
      end
      check("a_fill_full",  a_full, 1);
      check("a_fill_level", a_lvl,  16);
      check("a_fill_af",    a_af,   1);
      check("a_fill_ovf",   a_ovf,  0);
      a_wd = 8'hFF;
      tick;
      a_wr = 1'b0;
      check("a_ovf_set",   a_ovf,  1);
      check("a_ovf_level", a_lvl,  16);
      for (int i = 0; i < 16; i++) begin
         check("a_drain_data", a_rdat, 64'(i));
         check("a_drain_rv",   a_rv,   1);
         a_rd = 1'b1;
         tick;
      end
      a_rd = 1'b0;
      check("a_drain_empty", a_empty, 1);
      check("a_drain_level", a_lvl,   0);
      check("a_ovf_sticky",  a_ovf,   1);
      a_cf = 1'b1;
      tick;
      a_cf = 1'b0;
      check("a_ovf_clear", a_ovf, 0);

      // Full with simultaneous read and write
      for (int i = 0; i < 16; i++) begin
         a_wr = 1'b1; a_wd = 8'(i);
         tick;
      end
      a_rd = 1'b1; a_wd = 8'hAA;
      tick;
      a_wr = 1'b0; a_rd = 1'b0;
      check("a_rw_full_level", a_lvl,  16);
      check("a_rw_full_full",  a_full, 1);
      check("a_rw_full_ovf",   a_ovf,  0);
      for (int i = 0; i < 16; i++) begin
         check("a_rw_full_data", a_rdat, (i < 15) ? 64'(i + 1) : 64'hAA);
         a_rd = 1'b1;
         tick;
      end
      a_rd = 1'b0;
      check("a_rw_full_empty", a_empty, 1);

      // Empty with simultaneous read and write
      a_wr = 1'b1; a_rd = 1'b1; a_wd = 8'h55;
      tick;
      a_wr = 1'b0; a_rd = 1'b0;
      check("a_rw_empty_level", a_lvl,  1);
      check("a_rw_empty_unf",   a_unf,  1);
      check("a_rw_empty_data",  a_rdat, 8'h55);
      a_rd = 1'b1;
      tick;
      check("a_rw_empty_drained", a_empty, 1);

      // Clear with a same-cycle underflow keeps the flag; a lone clear drops it
      a_cf = 1'b1;
      tick;
      check("a_clr_vs_err", a_unf, 1);
      a_rd = 1'b0;
      tick;
      a_cf = 1'b0;
      check("a_clr_alone", a_unf, 0);

      // Flush beats write; sticky flag survives flush; reset clears flags
      a_rd = 1'b1;
      tick;
      a_rd = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a_wr = 1'b1; a_wd = 8'(8'h10 + i);
         tick;
      end
      check("a_pre_flush_level", a_lvl, 8);
      a_fl = 1'b1; a_wd = 8'hEE;
      tick;
      a_fl = 1'b0; a_wr = 1'b0;
      check("a_flush_level", a_lvl,   0);
      check("a_flush_empty", a_empty, 1);
      check("a_flush_unf",   a_unf,   1);
      a_rst = 1'b1;
      tick;
      a_rst = 1'b0;
      check("a_rerst_unf",   a_unf,   0);
      check("a_rerst_ovf",   a_ovf,   0);
      check("a_rerst_ae",    a_ae,    1);
      check("a_rerst_empty", a_empty, 1);
      a_wr = 1'b1; a_wd = 8'h77;
      tick;
      a_wr = 1'b0;
      check("a_post_rst_data",  a_rdat, 8'h77);
      check("a_post_rst_level", a_lvl,  1);

      // Non-power-of-two depth: pointers wrap at 4
      for (int r = 0; r < 4; r++) begin
         for (int j = 0; j < 3; j++) begin
            b_wr = 1'b1; b_wd = 8'(r * 3 + j + 1);
            tick;
         end
         b_wr = 1'b0;
         check("b_level", b_lvl, 3);
         check("b_af",    b_af,  1);
         check("b_ae",    b_ae,  0);
         for (int j = 0; j < 3; j++) begin
            exp_b = 8'(r * 3 + j + 1);
            check("b_data", b_rdat, exp_b);
            b_rd = 1'b1;
            tick;
         end
         b_rd = 1'b0;
         check("b_empty", b_empty, 1);
      end

      // Registered read: data and valid one cycle after the read edge
      c_wr = 1'b1; c_wd = 8'h3C;
      tick;
      c_wr = 1'b0;
      check("c_no_read_rv", c_rv, 0);
      c_rd = 1'b1;
      tick;
      c_rd = 1'b0;
      check("c_read_rv",   c_rv,   1);
      check("c_read_data", c_rdat, 8'h3C);
      tick;
      check("c_rv_pulse", c_rv,   0);
      check("c_hold",     c_rdat, 8'h3C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
